// File: rtl/multi_timer_controller_pkg.sv
// Shared constants for the multi-channel timer block: bus encodings,
// register offsets, CTRL bit positions and the channel state type.
package multi_timer_controller_pkg;

  localparam int unsigned BUS_WIDTH   = 32;
  localparam int unsigned BUS_ACC_CNT = 3;
  localparam int unsigned ACC_W       = $clog2(BUS_ACC_CNT);

  localparam logic [ACC_W-1:0] ACC_BYTE = ACC_W'(0);
  localparam logic [ACC_W-1:0] ACC_HALF = ACC_W'(1);
  localparam logic [ACC_W-1:0] ACC_WORD = ACC_W'(2);

  localparam int unsigned CH_STRIDE = 16;
  localparam int unsigned IRQ_ADDR  = 32'hF0;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_COUNT = 2'd1;
  localparam logic [1:0] REG_CMP   = 2'd2;
  localparam logic [1:0] REG_STAT  = 2'd3;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_PERIODIC = 1;
  localparam int unsigned CTRL_IE       = 2;
  localparam int unsigned CTRL_PSC_LSB  = 8;

  typedef enum logic [0:0] {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/multi_timer_controller_if.sv
// Peripheral bus port of the timer block: one-cycle req strobe, resp/fault/rdata one cycle later.
interface multi_timer_controller_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0]                                addr;
  logic                                             w_rb;
  logic [multi_timer_controller_pkg::ACC_W-1:0]     acc;
  logic [multi_timer_controller_pkg::BUS_WIDTH-1:0] wdata;
  logic [multi_timer_controller_pkg::BUS_WIDTH-1:0] rdata;
  logic                                             req;
  logic                                             resp;
  logic                                             fault;

  modport master (
    output addr, w_rb, acc, wdata, req,
    input  rdata, resp, fault
  );

  modport slave (
    input  addr, w_rb, acc, wdata, req,
    output rdata, resp, fault
  );
endinterface

// File: rtl/multi_timer_controller_timer_channel.sv
// One timer channel: prescaler, 32-bit up counter, compare match,
// one-shot/periodic mode and sticky pending flag.
module timer_channel
  import multi_timer_controller_pkg::*;
#(
  parameter int unsigned PSC_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ctrl_wr,
  input  logic                 count_wr,
  input  logic                 cmp_wr,
  input  logic                 stat_w1c,
  input  logic [BUS_WIDTH-1:0] wdata,
  output logic                 en,
  output logic                 periodic,
  output logic                 ie,
  output logic [PSC_W-1:0]     prescale,
  output logic [BUS_WIDTH-1:0] count,
  output logic [BUS_WIDTH-1:0] cmp,
  output logic                 pend,
  output logic                 irq_req_c
);

  ch_state_e        state_q, state_d;
  logic [PSC_W-1:0] psc_q;
  logic             tick_c;
  logic             match_c;

  assign en        = (state_q == CH_RUN);
  assign tick_c    = en && (psc_q == prescale);
  assign match_c   = tick_c && (count == cmp);
  assign irq_req_c = pend & ie;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= CH_IDLE;
    else     state_q <= state_d;
  end

  // A CTRL write always decides EN, even in the cycle of a one-shot match.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CH_IDLE: if (ctrl_wr && wdata[CTRL_EN]) state_d = CH_RUN;
      CH_RUN: begin
        if (ctrl_wr)                      state_d = wdata[CTRL_EN] ? CH_RUN : CH_IDLE;
        else if (match_c && !periodic)    state_d = CH_IDLE;
      end
      default: state_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 psc_q <= '0;
    else if (!en || ctrl_wr) psc_q <= '0;
    else if (tick_c)         psc_q <= '0;
    else                     psc_q <= psc_q + PSC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      periodic <= 1'b0;
      ie       <= 1'b0;
      prescale <= '0;
    end else if (ctrl_wr) begin
      periodic <= wdata[CTRL_PERIODIC];
      ie       <= wdata[CTRL_IE];
      prescale <= wdata[CTRL_PSC_LSB +: PSC_W];
    end
  end

  // Bus writes take priority over the hardware count update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      count <= '0;
    else if (count_wr)            count <= wdata;
    else if (match_c && periodic) count <= '0;
    else if (tick_c && !match_c)  count <= count + BUS_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cmp <= '0;
    else if (cmp_wr) cmp <= wdata;
  end

  // Hardware set beats a same-cycle write-1-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       pend <= 1'b0;
    else if (match_c)              pend <= 1'b1;
    else if (stat_w1c && wdata[0]) pend <= 1'b0;
  end

endmodule

// File: rtl/multi_timer_controller.sv
// N_CH independent timers behind one bus slave: decode, fault check,
// read mux, registered response and interrupt.
module multi_timer_controller
  import multi_timer_controller_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned PSC_W  = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  multi_timer_controller_if.slave bus,
  output logic                    interrupt
);

  localparam int unsigned CH_SHIFT = $clog2(CH_STRIDE);
  localparam int unsigned CH_W     = ADDR_W - CH_SHIFT;

  logic [CH_W-1:0]      ch_idx_c;
  logic [1:0]           reg_off_c;
  logic                 is_irq_c;
  logic                 fault_c;
  logic                 wr_ok_c;
  logic [BUS_WIDTH-1:0] rd_val_c;

  logic [N_CH-1:0]      en_v, periodic_v, ie_v, pend_v, irq_v;
  logic [PSC_W-1:0]     prescale_v [N_CH];
  logic [BUS_WIDTH-1:0] count_v    [N_CH];
  logic [BUS_WIDTH-1:0] cmp_v      [N_CH];

  assign ch_idx_c  = bus.addr[ADDR_W-1:CH_SHIFT];
  assign reg_off_c = bus.addr[CH_SHIFT-1:2];
  assign is_irq_c  = (bus.addr == ADDR_W'(IRQ_ADDR));

  // The IRQ word lives in the slot of channel index 15, so it is exempt from the range check.
  assign fault_c = (bus.acc != ACC_WORD)
                || (bus.addr[1:0] != 2'b00)
                || (!is_irq_c && (32'(ch_idx_c) >= N_CH))
                || (is_irq_c && bus.w_rb);
  assign wr_ok_c = bus.req && bus.w_rb && !fault_c;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic sel_c;
    assign sel_c = wr_ok_c && (ch_idx_c == CH_W'(c));

    timer_channel #(.PSC_W(PSC_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .ctrl_wr   (sel_c && (reg_off_c == REG_CTRL)),
      .count_wr  (sel_c && (reg_off_c == REG_COUNT)),
      .cmp_wr    (sel_c && (reg_off_c == REG_CMP)),
      .stat_w1c  (sel_c && (reg_off_c == REG_STAT)),
      .wdata     (bus.wdata),
      .en        (en_v[c]),
      .periodic  (periodic_v[c]),
      .ie        (ie_v[c]),
      .prescale  (prescale_v[c]),
      .count     (count_v[c]),
      .cmp       (cmp_v[c]),
      .pend      (pend_v[c]),
      .irq_req_c (irq_v[c])
    );
  end

  // Read mux; unused bits and unmapped addresses read as zero.
  always_comb begin
    rd_val_c = '0;
    if (is_irq_c) begin
      rd_val_c = BUS_WIDTH'(irq_v);
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (32'(ch_idx_c) == c) begin
          case (reg_off_c)
            REG_CTRL: begin
              rd_val_c[CTRL_EN]                    = en_v[c];
              rd_val_c[CTRL_PERIODIC]              = periodic_v[c];
              rd_val_c[CTRL_IE]                    = ie_v[c];
              rd_val_c[CTRL_PSC_LSB +: PSC_W]      = prescale_v[c];
            end
            REG_COUNT: rd_val_c = count_v[c];
            REG_CMP:   rd_val_c = cmp_v[c];
            default:   rd_val_c[0] = pend_v[c];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.resp  <= 1'b0;
      bus.fault <= 1'b0;
      bus.rdata <= '0;
      interrupt <= 1'b0;
    end else begin
      bus.resp  <= bus.req;
      bus.fault <= bus.req && fault_c;
      bus.rdata <= (bus.req && !bus.w_rb && !fault_c) ? rd_val_c : '0;
      interrupt <= |irq_v;
    end
  end

endmodule

// File: tb/tb_multi_timer_controller.sv
// Bench for multi_timer_controller: directed steps plus random bus traffic,
// every cycle compared against a cycle-stepped behavioural model.
module tb_multi_timer_controller;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned PSC_W = 8;
  localparam logic [1:0]  WORD  = 2'd2;

  logic clk;
  logic rst;
  logic interrupt;

  multi_timer_controller_if #(.ADDR_W(8)) bus ();

  multi_timer_controller #(.N_CH(N_CH), .PSC_W(PSC_W), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .interrupt (interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: age counts enabled clocks since the last CTRL write.
  bit          m_en   [N_CH];
  bit          m_per  [N_CH];
  bit          m_ie   [N_CH];
  bit          m_pend [N_CH];
  int unsigned m_psc  [N_CH];
  int unsigned m_age  [N_CH];
  logic [31:0] m_count[N_CH];
  logic [31:0] m_cmp  [N_CH];

  logic        exp_resp, exp_fault, exp_int;
  logic [31:0] exp_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_en[c] = 0; m_per[c] = 0; m_ie[c] = 0; m_pend[c] = 0;
      m_psc[c] = 0; m_age[c] = 0; m_count[c] = '0; m_cmp[c] = '0;
    end
  endtask

  function automatic bit is_fault(input logic w, input logic [1:0] acc, input logic [7:0] a);
    if (acc != WORD || a[1:0] != 2'b00) return 1'b1;
    if (a == 8'hF0) return w;
    return (32'(a[7:4]) >= N_CH);
  endfunction

  function automatic logic [31:0] irq_word();
    logic [31:0] v;
    v = '0;
    for (int c = 0; c < N_CH; c++) v[c] = m_pend[c] & m_ie[c];
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int unsigned ch;
    if (a == 8'hF0) return irq_word();
    ch = 32'(a[7:4]);
    case (a[3:2])
      2'd0:    return {16'h0, 8'(m_psc[ch]), 5'h0, m_ie[ch], m_per[ch], m_en[ch]};
      2'd1:    return m_count[ch];
      2'd2:    return m_cmp[ch];
      default: return {31'h0, m_pend[ch]};
    endcase
  endfunction

  // Advance the model by one clock using the bus inputs currently applied.
  task automatic model_step();
    bit          f;
    int unsigned ch;
    f         = is_fault(bus.w_rb, bus.acc, bus.addr);
    exp_resp  = bus.req;
    exp_fault = bus.req && f;
    exp_rdata = (bus.req && !bus.w_rb && !f) ? model_read(bus.addr) : 32'h0;
    exp_int   = (irq_word() != 32'h0);
    ch        = 32'(bus.addr[7:4]);
    for (int unsigned c = 0; c < N_CH; c++) begin
      bit matched;
      matched = 1'b0;
      if (m_en[c]) begin
        if ((m_age[c] % (m_psc[c] + 1)) == m_psc[c]) begin
          if (m_count[c] == m_cmp[c]) begin
            matched   = 1'b1;
            m_pend[c] = 1'b1;
            if (m_per[c]) m_count[c] = '0;
            else          m_en[c]    = 1'b0;
          end else begin
            m_count[c] = m_count[c] + 32'd1;
          end
        end
        m_age[c]++;
      end
      if (bus.req && bus.w_rb && !f && ch == c) begin
        case (bus.addr[3:2])
          2'd0: begin
            m_en[c]  = bus.wdata[0];
            m_per[c] = bus.wdata[1];
            m_ie[c]  = bus.wdata[2];
            m_psc[c] = 32'(bus.wdata[15:8]);
            m_age[c] = 0;
          end
          2'd1:    m_count[c] = bus.wdata;
          2'd2:    m_cmp[c]   = bus.wdata;
          default: if (bus.wdata[0] && !matched) m_pend[c] = 1'b0;
        endcase
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("resp", 32'(bus.resp), 32'(exp_resp));
    chk("fault", 32'(bus.fault), 32'(exp_fault));
    chk("rdata", bus.rdata, exp_rdata);
    chk("interrupt", 32'(interrupt), 32'(exp_int));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic bus_op(input logic w, input logic [1:0] acc, input logic [7:0] a, input logic [31:0] wd);
    bus.req = 1'b1; bus.w_rb = w; bus.acc = acc; bus.addr = a; bus.wdata = wd;
    cycle();
    bus.req = 1'b0; bus.w_rb = 1'b0; bus.acc = WORD; bus.addr = '0; bus.wdata = '0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] wd);
    bus_op(1'b1, WORD, a, wd);
  endtask

  task automatic rd(input logic [7:0] a);
    bus_op(1'b0, WORD, a, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req = 1'b0; bus.w_rb = 1'b0; bus.acc = WORD; bus.addr = '0; bus.wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_resp", 32'(bus.resp), 32'h0);
    chk("reset_fault", 32'(bus.fault), 32'h0);
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_interrupt", 32'(interrupt), 32'h0);
    rst = 1'b0;

    // All registers read zero after reset.
    for (int c = 0; c < N_CH; c++)
      for (int r = 0; r < 4; r++) rd(8'(c * 16 + r * 4));
    rd(8'hF0);

    // Ch0 periodic, CMP=3, PRESCALE=0.
    wr(8'h08, 32'd3);
    wr(8'h00, 32'h7);
    idle(3);
    rd(8'h0C);
    chk("ch0_pend_before_match", bus.rdata, 32'h0);
    chk("ch0_irq_before", 32'(interrupt), 32'h0);
    rd(8'h04);
    chk("ch0_count_reload", bus.rdata, 32'h0);
    chk("ch0_irq_rise", 32'(interrupt), 32'h1);
    rd(8'h0C);
    chk("ch0_pend_set", bus.rdata, 32'h1);
    wr(8'h0C, 32'h1);
    idle(1);
    chk("ch0_irq_fall", 32'(interrupt), 32'h0);
    idle(1);
    chk("ch0_irq_again", 32'(interrupt), 32'h1);
    wr(8'h00, 32'h0);
    wr(8'h0C, 32'h1);

    // Ch1 one-shot, CMP=2, PRESCALE=2.
    wr(8'h18, 32'd2);
    wr(8'h10, 32'h205);
    idle(8);
    rd(8'h1C);
    chk("ch1_pend_early", bus.rdata, 32'h0);
    rd(8'h10);
    chk("ch1_en_cleared", bus.rdata, 32'h204);
    rd(8'h14);
    chk("ch1_count_holds", bus.rdata, 32'h2);
    rd(8'h1C);
    chk("ch1_pend_set", bus.rdata, 32'h1);
    wr(8'h1C, 32'h1);
    idle(12);
    rd(8'h1C);
    chk("ch1_no_repend", bus.rdata, 32'h0);

    // Ch2 wrap from 0xFFFFFFFF without a flag, then match at 5.
    wr(8'h24, 32'hFFFF_FFFF);
    wr(8'h28, 32'd5);
    wr(8'h20, 32'h1);
    idle(1);
    rd(8'h24);
    chk("ch2_wrapped", bus.rdata, 32'h0);
    rd(8'h2C);
    chk("ch2_no_wrap_flag", bus.rdata, 32'h0);
    idle(4);
    rd(8'h2C);
    chk("ch2_pend_at_5", bus.rdata, 32'h1);
    rd(8'h20);
    chk("ch2_oneshot_off", bus.rdata, 32'h0);
    wr(8'h2C, 32'h1);

    // Faults leave state untouched.
    bus_op(1'b0, 2'd0, 8'h04, 32'h0);
    chk("fault_byte", 32'(bus.fault), 32'h1);
    rd(8'h02);
    chk("fault_misaligned", 32'(bus.fault), 32'h1);
    rd(8'(N_CH * 16));
    chk("fault_channel", 32'(bus.fault), 32'h1);
    wr(8'hF0, 32'hFFFF_FFFF);
    chk("fault_irq_write", 32'(bus.fault), 32'h1);
    bus_op(1'b1, 2'd1, 8'h18, 32'h55);
    rd(8'h18);
    chk("fault_no_write", bus.rdata, 32'h2);

    // Collisions on ch3.
    wr(8'h38, 32'd1);
    wr(8'h30, 32'h3);
    idle(1);
    wr(8'h3C, 32'h1);
    rd(8'h3C);
    chk("w1c_vs_match", bus.rdata, 32'h1);
    wr(8'h38, 32'h100);
    wr(8'h30, 32'h301);
    idle(3);
    wr(8'h34, 32'h10);
    rd(8'h34);
    chk("count_write_wins", bus.rdata, 32'h10);
    wr(8'h30, 32'h0);
    wr(8'h3C, 32'h1);

    // Random traffic, back-to-back and with gaps.
    for (int i = 0; i < 150; i++) begin
      int unsigned ch, off;
      logic [7:0]  a;
      logic [1:0]  acc;
      logic [31:0] wd;
      ch  = $urandom_range(0, N_CH);
      off = $urandom_range(0, 3);
      a   = 8'(ch * 16 + off * 4);
      if ($urandom_range(0, 9) == 0)  a = 8'hF0;
      if ($urandom_range(0, 15) == 0) a[1:0] = 2'($urandom_range(1, 3));
      acc = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1)) : WORD;
      if (off == 0)      wd = (32'($urandom_range(0, 3)) << 8) | 32'($urandom_range(0, 7));
      else if (off == 3) wd = 32'($urandom_range(0, 1));
      else               wd = 32'($urandom_range(0, 12));
      bus_op(1'($urandom_range(0, 1)), acc, a, wd);
      idle(int'($urandom_range(0, 3)));
    end

    // Async reset with a request in flight.
    wr(8'h04, 32'h0);
    wr(8'h08, 32'h0);
    wr(8'h00, 32'h7);
    idle(3);
    chk("pre_reset_irq", 32'(interrupt), 32'h1);
    bus.req = 1'b1; bus.w_rb = 1'b0; bus.acc = WORD; bus.addr = 8'h00;
    #3;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_no_resp", 32'(bus.resp), 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_interrupt", 32'(interrupt), 32'h0);
    rst = 1'b0;
    bus.req = 1'b0;
    rd(8'h00);
    chk("rst_ctrl_zero", bus.rdata, 32'h0);
    rd(8'h0C);
    rd(8'hF0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
